ifetch_byte_assembler: RTL

//  Instruction-fetch front end for the byte-wide instruction BRAM (8b x 4096, 1-cycle read latency).

---
 rtl/ifetch_byte_assembler_pkg.sv | 25 ++
 rtl/ifetch_byte_assembler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ifetch_byte_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_byte_assembler_pkg
// Description : Shared constants and fetch FSM state encoding for the
//               byte-wide instruction fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_byte_assembler_pkg;

    // Default BRAM byte-address width (8b x 4096)
    localparam int          C_ADDR_W   = 12;

    // RV32I canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] C_RV32_NOP = 32'h0000_0013;

    // Fetch FSM: IDLE absorbs reset release, FETCH issues bytes,
    // HOLD parks a finished word while the output slot is occupied.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_byte_assembler
// Description : Walks the PC through a byte-wide instruction BRAM, gathers
//               four little-endian bytes into a 32-bit RV32I word and hands
//               {instr, instr_pc} to decode over valid/ready. A redirect
//               flushes everything and restarts fetch at the new PC.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_byte_assembler
    import ifetch_byte_assembler_pkg::*;
#(
    parameter int                ADDR_W   = C_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_byte_cnt;
    logic              r_inflight;
    logic [1:0]        r_lane;
    logic [31:0]       r_asm;
    logic              r_asm_full;
    logic              r_instr_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;

    logic              w_drain;
    logic              w_word_done;
    logic              w_stall;
    logic              w_issue;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_word_pc;

    // The lane-3 byte arriving on mem_rdata completes the word. If the output
    // slot cannot take it, the byte issue of that same cycle is suppressed so
    // the parked word in r_asm is never overwritten by a following byte.
    assign w_drain     = r_instr_valid && instr_ready;
    assign w_word_done = r_inflight && (r_lane == 2'd3);
    assign w_word      = {mem_rdata, r_asm[23:0]};
    assign w_stall     = w_word_done && r_instr_valid && !instr_ready;
    assign w_issue     = (r_state == S_FETCH) && !w_stall;
    // r_pc has already advanced past the word once its last byte was issued
    assign w_word_pc   = r_pc - ADDR_W'(4);

    assign mem_en      = w_issue;
    assign mem_addr    = w_issue ? (r_pc + ADDR_W'(r_byte_cnt)) : '0;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect always lands in FETCH
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: if (w_stall) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_drain) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
        if (redirect_valid) begin
            w_state_nxt = S_FETCH;
        end
    end

    // PC walk and in-flight read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_byte_cnt <= 2'd0;
            r_inflight <= 1'b0;
            r_lane     <= 2'd0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc & ~ADDR_W'(3);
            r_byte_cnt <= 2'd0;
            r_inflight <= 1'b0;
            r_lane     <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_lane     <= r_byte_cnt;
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'd3) begin
                    r_pc <= r_pc + ADDR_W'(4);
                end
            end
        end
    end

    // Byte-lane assembly and parking of a finished word that cannot leave yet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm      <= '0;
            r_asm_full <= 1'b0;
        end else if (redirect_valid) begin
            r_asm_full <= 1'b0;
        end else begin
            if (r_inflight && !w_word_done) begin
                r_asm[{r_lane, 3'b000} +: 8] <= mem_rdata;
            end
            if (w_stall) begin
                r_asm      <= w_word;
                r_asm_full <= 1'b1;
            end else if (r_asm_full && w_drain) begin
                r_asm_full <= 1'b0;
            end
        end
    end

    // Output slot: load a fresh or parked word when empty or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else if (redirect_valid) begin
            r_instr_valid <= 1'b0;
        end else if (w_word_done && (!r_instr_valid || instr_ready)) begin
            r_instr_valid <= 1'b1;
            r_instr       <= w_word;
            r_instr_pc    <= w_word_pc;
        end else if (r_asm_full && w_drain) begin
            r_instr_valid <= 1'b1;
            r_instr       <= r_asm;
            r_instr_pc    <= w_word_pc;
        end else if (w_drain) begin
            r_instr_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
